inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the memory controller's fetch port and downstream-feeding the decoder.
//  Holds the fetch PC and requests one 32-bit word at a time from the memory controller.
//  Pre-decodes each returned word for JAL and branch targets, and buffers fetched words in a circular instruction queue.
//  The queue is drained by the decoder. rob_clear_up flushes the unit and redirects it to the PC supplied by the ROB.
// PARAMETERS
//  IQ_DEPTH  8  instruction queue entries; power of two, >= 2
// PORTS
//  clk_in         in   1   system clock
//  rst_n_in       in   1   asynchronous, active-low reset
//  rdy_in         in   1   when low, all state frozen
//  rob_clear_up   in   1   flush request (mispredict)
//  rob_new_pc     in   32  redirect PC, valid with rob_clear_up
//  should_fetch   out  1   fetch request to memory controller
//  pc             out  32  fetch address to memory controller
//  fetch_ready    in   1   one-cycle pulse: fetched word valid
//  inst           in   32  fetched word
//  inst_addr      in   32  address of fetched word
//  iq_valid       out  1   queue head valid
//  iq_inst        out  32  head instruction
//  iq_pc          out  32  head instruction address
//  iq_pred_taken  out  1   head predicted taken (JAL or backward branch)
//  iq_pred_pc     out  32  predicted next PC of head
//  decoder_ready  in   1   decoder pops head when iq_valid && decoder_ready
// BEHAVIOUR
//  Clock and reset
//  - One clock domain: clk_in. Reset is asynchronous and active-low (rst_n_in).
//  - While rst_n_in is low: pc_reg=0, state=IDLE, head=tail=count=0.
//  - Reset outputs: should_fetch=0, pc=0, iq_valid=0, iq_inst=0, iq_pc=0, iq_pred_taken=0, iq_pred_pc=0.
//  - Reset mid-fetch abandons the request; no queue entry is written.
//  Priority at each rising edge (rdy_in high): rob_clear_up, then normal operation.
//  rdy_in low: no state changes, outputs hold.
//  FSM states: IDLE, FETCH. Combinational outputs: should_fetch = (state==FETCH); pc = pc_reg.
//  - IDLE -> FETCH when count < IQ_DEPTH.
//  - FETCH, accept condition: fetch_ready && inst_addr==pc_reg.
//    - On accept: push {inst, pc_reg, taken, next}; set pc_reg <= next.
//    - Next state is FETCH if (count_after_push) < IQ_DEPTH, else IDLE.
//    - should_fetch stays high across back-to-back fetches; the controller samples the new pc on its idle cycle.
//  - fetch_ready with inst_addr != pc_reg is ignored (stale response).
//  Pre-decode (opcode = inst[6:0])
//  - 1101111 JAL: taken=1; next = pc_reg + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//  - 1100011 branch: imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//    taken = inst[31]; next = taken ? pc_reg+imm : pc_reg+4.
//  - All other opcodes, JALR included: taken=0; next = pc_reg+4.
//  - All address arithmetic is 32-bit modulo 2^32; carries are discarded.
//  Queue
//  - head and tail are clog2(IQ_DEPTH)-bit and wrap naturally; count is clog2(IQ_DEPTH)+1 bits.
//  - iq_valid = (count != 0); iq_* are driven from the head entry.
//  - Pop when iq_valid && decoder_ready.
//  - Push and pop in the same cycle leave count unchanged.
//  - Push never occurs when full, because FETCH is only entered or held with free space.
//  - A pop at full in the same cycle as fetch_ready is legal.
//  Flush (rob_clear_up high, rdy_in high)
//  - head=tail=count=0; pc_reg <= rob_new_pc; state <= IDLE.
//  - A fetch_ready arriving in the same cycle is dropped, and a pop in that cycle has no effect.
//  - should_fetch rises on the next edge, with pc = rob_new_pc.
//  Latency: the first request is issued 1 cycle after reset release or flush.
//  A fetched word is visible at iq_* the cycle after fetch_ready.
// TESTING
//  1. Sequential fill: reset release, ram returns NOPs at 0,4,8,..., decoder_ready=0.
//     -> 8 entries with iq_pc 0x0..0x1C; should_fetch drops once count=8; no 9th push.
//  2. JAL: word 0x0080006F at pc 0x10.
//     -> entry has iq_pred_taken=1, iq_pred_pc=0x18; next request pc=0x18.
//  3. Backward branch: 0xFE000EE3 at 0x20.
//     -> iq_pred_taken=1, iq_pred_pc=0x1C. Same with inst[31]=0 and imm=+8 -> taken=0, pred 0x24.
//  4. Flush mid-fetch: rob_clear_up with rob_new_pc=0x100 while FETCH and queue holds 3 entries.
//     -> iq_valid=0 next cycle; the same-cycle fetch_ready is ignored; the next request uses pc=0x100.
//  5. Full with pop: queue full, decoder_ready=1 for one cycle.
//     -> count 8->7, FETCH re-entered, refill to 8; no overflow and no lost entries (check iq_pc order).
//  6. rdy_in low for 5 cycles mid-fetch, with fetch_ready and decoder_ready held high.
//     -> no pc, queue or state change; operation resumes identically after rdy_in returns high.

Source files
------------

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Instruction fetch stage. Holds the fetch PC, requests one
//                32-bit word at a time from the memory controller,
//                pre-decodes JAL/branch targets and buffers fetched words in
//                a circular instruction queue drained by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int IQ_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [31:0] rob_new_pc,
    output logic        should_fetch,
    output logic [31:0] pc,
    input  logic        fetch_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    output logic [31:0] iq_pred_pc,
    input  logic        decoder_ready
);

    localparam int                 c_PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(IQ_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_FETCH = 1'b1;

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [31:0]        r_pc_reg;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;

    // Queue storage; no reset needed because entries are only read when valid.
    logic [31:0] r_iq_inst  [IQ_DEPTH];
    logic [31:0] r_iq_pc    [IQ_DEPTH];
    logic        r_iq_taken [IQ_DEPTH];
    logic [31:0] r_iq_pred  [IQ_DEPTH];

    logic [6:0]  w_opcode;
    logic [31:0] w_jal_imm;
    logic [31:0] w_br_imm;
    logic        w_taken;
    logic [31:0] w_next_pc;
    logic        w_accept;
    logic        w_pop;

    assign w_opcode  = inst[6:0];
    assign w_jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_br_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    // A response is only taken while requesting and only if it answers the current PC;
    // anything else is a stale reply to a request abandoned by a flush.
    assign w_accept = (r_state == c_FETCH) && fetch_ready && (inst_addr == r_pc_reg);
    assign w_pop    = iq_valid && decoder_ready;

    // Pre-decode: JAL always taken, branches predicted taken when backward (sign bit set).
    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = r_pc_reg + 32'd4;
        if (w_opcode == c_OP_JAL) begin
            w_taken   = 1'b1;
            w_next_pc = r_pc_reg + w_jal_imm;
        end else if (w_opcode == c_OP_BRANCH) begin
            w_taken = inst[31];
            if (inst[31]) begin
                w_next_pc = r_pc_reg + w_br_imm;
            end
        end
    end

    // Occupancy after this cycle's push/pop, ignoring flush.
    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Next-state logic: only request while the queue has room for the reply.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_count < c_DEPTH) begin
                    w_state_next = c_FETCH;
                end
            end
            c_FETCH: begin
                if (w_accept) begin
                    w_state_next = (w_count_next < c_DEPTH) ? c_FETCH : c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Control state: flush has priority over normal operation; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= c_IDLE;
            r_pc_reg <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                r_state  <= c_IDLE;
                r_pc_reg <= rob_new_pc;
                r_head   <= '0;
                r_tail   <= '0;
                r_count  <= '0;
            end else begin
                r_state <= w_state_next;
                r_count <= w_count_next;
                if (w_accept) begin
                    r_pc_reg <= w_next_pc;
                    r_tail   <= r_tail + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
            end
        end
    end

    // Write the accepted word and its prediction into the tail slot.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear_up && w_accept) begin
            r_iq_inst[r_tail]  <= inst;
            r_iq_pc[r_tail]    <= r_pc_reg;
            r_iq_taken[r_tail] <= w_taken;
            r_iq_pred[r_tail]  <= w_next_pc;
        end
    end

    assign should_fetch  = (r_state == c_FETCH);
    assign pc            = r_pc_reg;
    assign iq_valid      = (r_count != '0);
    // Head fields read as zero when empty so outputs are clean after reset/flush.
    assign iq_inst       = iq_valid ? r_iq_inst[r_head]  : 32'd0;
    assign iq_pc         = iq_valid ? r_iq_pc[r_head]    : 32'd0;
    assign iq_pred_taken = iq_valid ? r_iq_taken[r_head] : 1'b0;
    assign iq_pred_pc    = iq_valid ? r_iq_pred[r_head]  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int IQ_DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        rob_clear_up = 1'b0;
    logic [31:0] rob_new_pc = '0;
    logic        should_fetch;
    logic [31:0] pc;
    logic        fetch_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] inst_addr = '0;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic [31:0] iq_pred_pc;
    logic        decoder_ready = 1'b0;

    inst_fetch_unit #(.IQ_DEPTH(IQ_DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .rob_clear_up  (rob_clear_up),
        .rob_new_pc    (rob_new_pc),
        .should_fetch  (should_fetch),
        .pc            (pc),
        .fetch_ready   (fetch_ready),
        .inst          (inst),
        .inst_addr     (inst_addr),
        .iq_valid      (iq_valid),
        .iq_inst       (iq_inst),
        .iq_pc         (iq_pc),
        .iq_pred_taken (iq_pred_taken),
        .iq_pred_pc    (iq_pred_pc),
        .decoder_ready (decoder_ready)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] pred;
    } entry_t;

    // Reference model: a plain queue of fetched entries, the fetch PC and a requesting flag.
    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic        m_req;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Prediction computed from the immediate's numeric value.
    function automatic entry_t predecode(input logic [31:0] w, input logic [31:0] at);
        entry_t e;
        int     off;
        e.inst  = w;
        e.pc    = at;
        e.taken = 1'b0;
        e.pred  = at + 32'd4;
        if (w[6:0] == 7'h6F) begin
            off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
            e.taken = 1'b1;
            e.pred  = at + 32'(off);
        end else if (w[6:0] == 7'h63) begin
            off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                  - (w[31] ? 4096 : 0);
            e.taken = w[31];
            if (w[31]) e.pred = at + 32'(off);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0013;
            1:       return {r[31:7], 7'h6F};
            2:       return {r[31:7], 7'h63};
            3:       return {r[31:7], 7'h67};
            default: return r;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        entry_t h;
        logic   v;
        v = (m_q.size() != 0);
        h = v ? m_q[0] : '0;
        check_val({tag, ".req"}, {should_fetch, pc}, {m_req, m_pc});
        check_val({tag, ".head"}, {iq_valid, iq_pred_taken, iq_inst, iq_pc, iq_pred_pc},
                  {v, h.taken, h.inst, h.pc, h.pred});
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model, check at next negedge.
    task automatic cyc(input logic rdy, input logic clr, input logic [31:0] npc,
                       input logic fr, input logic [31:0] w, input logic [31:0] addr,
                       input logic dr, input string tag);
        int     n0;
        bit     acc;
        bit     pop;
        entry_t e;
        rdy_in = rdy; rob_clear_up = clr; rob_new_pc = npc;
        fetch_ready = fr; inst = w; inst_addr = addr; decoder_ready = dr;
        if (rdy) begin
            if (clr) begin
                m_q.delete();
                m_pc  = npc;
                m_req = 1'b0;
            end else begin
                n0  = m_q.size();
                acc = m_req && fr && (addr == m_pc);
                pop = (n0 != 0) && dr;
                if (pop) void'(m_q.pop_front());
                if (acc) begin
                    e = predecode(w, m_pc);
                    m_q.push_back(e);
                    m_pc  = e.pred;
                    m_req = (m_q.size() < IQ_DEPTH);
                end else if (!m_req) begin
                    m_req = (n0 < IQ_DEPTH);
                end
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
        check_outputs(tag);
    endtask

    // Memory answers every cycle with a NOP at the current PC.
    task automatic feed(input logic dr, input string tag);
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0013, m_pc, dr, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, tag);
    endtask

    // Asynchronous reset asserted mid clock-low phase, with a matching response in flight.
    task automatic do_reset();
        fetch_ready = 1'b1;
        inst_addr   = m_pc;
        #2 rst_n_in = 1'b0;
        m_q.delete();
        m_pc  = 32'd0;
        m_req = 1'b0;
        #1 check_outputs("reset_async");
        @(posedge clk_in);
        @(negedge clk_in);
        check_outputs("reset_hold");
        rst_n_in = 1'b1;
    endtask

    initial begin
        @(negedge clk_in);
        do_reset();

        // Sequential fill with decoder stalled; the 9th reply must be ignored.
        for (int i = 0; i < 12; i++) feed(1'b0, "fill");
        check_val("fill.stop", {should_fetch, iq_pc}, {1'b0, 32'h0});
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, "drain");
        check_val("fill.order", {iq_valid, iq_pc}, {1'b1, 32'h4});

        // JAL at 0x10.
        cyc(1'b1, 1'b1, 32'h10, 1'b0, 32'd0, 32'd0, 1'b0, "jal.flush");
        idle("jal.idle");
        check_val("jal.request", {should_fetch, pc}, {1'b1, 32'h10});
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h0080_006F, 32'h10, 1'b0, "jal");
        check_val("jal.entry", {iq_valid, iq_pred_taken, iq_pred_pc, pc}, {1'b1, 1'b1, 32'h18, 32'h18});

        // Backward branch at 0x20, then forward branch with inst[31]=0.
        cyc(1'b1, 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0, "brb.flush");
        idle("brb.idle");
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'hFE00_0EE3, 32'h20, 1'b0, "brb");
        check_val("brb.entry", {iq_pred_taken, iq_pred_pc}, {1'b1, 32'h1C});
        cyc(1'b1, 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0, "brf.flush");
        idle("brf.idle");
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0463, 32'h20, 1'b0, "brf");
        check_val("brf.entry", {iq_pred_taken, iq_pred_pc, pc}, {1'b0, 32'h24, 32'h24});

        // Flush mid-fetch with three entries, matching reply and pop in the same cycle.
        cyc(1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 32'd0, 1'b0, "mid.flush0");
        idle("mid.idle");
        for (int i = 0; i < 3; i++) feed(1'b0, "mid.fill");
        cyc(1'b1, 1'b1, 32'h100, 1'b1, 32'h0000_0013, m_pc, 1'b1, "mid.flush");
        check_val("mid.empty", {iq_valid, should_fetch}, 2'b00);
        idle("mid.redirect");
        check_val("mid.newpc", {should_fetch, pc}, {1'b1, 32'h100});

        // Full queue, one pop, refill to full.
        for (int i = 0; i < 10; i++) feed(1'b0, "full.fill");
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, "full.pop");
        check_val("full.pop_head", {iq_pc, should_fetch}, {32'h104, 1'b0});
        for (int i = 0; i < 4; i++) feed(1'b0, "full.refill");
        check_val("full.refilled", {should_fetch, iq_pc, pc}, {1'b0, 32'h104, 32'h124});

        // rdy_in low for five cycles with reply and pop held high.
        cyc(1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 32'd0, 1'b0, "stall.flush");
        idle("stall.idle");
        for (int i = 0; i < 2; i++) feed(1'b0, "stall.fill");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0013, m_pc, 1'b1, "stall");
            check_val("stall.frozen", {pc, iq_pc, should_fetch}, {32'h208, 32'h200, 1'b1});
        end
        for (int i = 0; i < 4; i++) feed(1'b1, "stall.resume");

        // Random traffic with stalls, flushes, stale replies and one mid-run reset.
        for (int i = 0; i < 2000; i++) begin
            logic        rdy;
            logic        clr;
            logic [31:0] npc;
            logic        fr;
            logic [31:0] addr;
            logic        dr;
            if (i == 1000) do_reset();
            rdy  = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            npc  = $urandom() & 32'hFFFF_FFFC;
            fr   = ($urandom_range(0, 9) < 6);
            addr = ($urandom_range(0, 9) == 0) ? (m_pc + 32'd4) : m_pc;
            dr   = ($urandom_range(0, 9) < 4);
            cyc(rdy, clr, npc, fr, rand_inst(), addr, dr, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
